// File: rtl/id_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : id_branch_hazard_ctrl
// Brief   : SPARC v8 decode-stage CTI resolution, 1-cycle hazard stall,
//           delay-slot annul, saturating event counters, sticky DCTI flag.
// Revision: 1.0
// ============================================================================
module id_branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic [31:0]      instr_id,
    input  logic [31:0]      pc_id,
    input  logic [3:0]       icc,
    input  logic             ex_setcc,
    input  logic             ex_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_jmpl,
    output logic [1:0]       pc_sel,
    output logic             fetch_le,
    output logic             ifid_le,
    output logic             ifid_clear,
    output logic             idex_bubble,
    output logic [31:0]      ta,
    output logic             taken,
    output logic             annul,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] annul_cnt,
    output logic             dcti_err
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ds_flag;
    logic             r_dcti_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_annul_cnt;

    logic             w_ds_next;
    logic             w_dcti_set;
    logic             w_stall_inc;
    logic             w_annul_inc;

    // Instruction field decode
    logic [1:0] w_op;
    logic [3:0] w_cond;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic       w_is_bicc;
    logic       w_is_call;
    logic       w_is_cti;
    logic       w_annul_bit;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_use_rd;

    assign w_op        = instr_id[31:30];
    assign w_cond      = instr_id[28:25];
    assign w_rs1       = instr_id[18:14];
    assign w_rs2       = instr_id[4:0];
    assign w_rd        = instr_id[29:25];
    assign w_annul_bit = instr_id[29];
    assign w_is_bicc   = (w_op == 2'b00) && (instr_id[24:22] == 3'b010);
    assign w_is_call   = (w_op == 2'b01);
    assign w_is_cti    = w_is_bicc | w_is_call;
    assign w_use_rs1   = w_op[1];
    assign w_use_rs2   = w_op[1] & ~instr_id[13];
    assign w_use_rd    = (w_op == 2'b11) && (instr_id[24:21] == 4'b0001);

    // Hazard detection
    logic w_load_use;
    logic w_icc_haz;
    logic w_hazard;

    assign w_load_use = ex_load && (ex_rd != 5'd0) &&
                        ((w_use_rs1 && (w_rs1 == ex_rd)) ||
                         (w_use_rs2 && (w_rs2 == ex_rd)) ||
                         (w_use_rd  && (w_rd  == ex_rd)));
    assign w_icc_haz  = w_is_bicc & ex_setcc;
    assign w_hazard   = w_load_use | w_icc_haz;

    // Branch condition from {N,Z,V,C}; cond[3] inverts the base test
    logic w_cond_base;
    logic w_cond_true;

    always_comb begin
        w_cond_base = 1'b0;
        unique case (w_cond[2:0])
            3'd0: w_cond_base = 1'b0;
            3'd1: w_cond_base = icc[2];
            3'd2: w_cond_base = icc[2] | (icc[3] ^ icc[1]);
            3'd3: w_cond_base = icc[3] ^ icc[1];
            3'd4: w_cond_base = icc[0] | icc[2];
            3'd5: w_cond_base = icc[0];
            3'd6: w_cond_base = icc[3];
            3'd7: w_cond_base = icc[1];
        endcase
        w_cond_true = w_cond[3] ? ~w_cond_base : w_cond_base;
    end

    // Target address
    logic [31:0] w_ta_bicc;
    logic [31:0] w_ta_call;

    assign w_ta_bicc = pc_id + {{8{instr_id[21]}}, instr_id[21:0], 2'b00};
    assign w_ta_call = pc_id + {instr_id[29:0], 2'b00};
    assign ta        = !R ? 32'd0 : (w_is_call ? w_ta_call : w_ta_bicc);

    // Next-state and fetch-control decode; everything idles while in reset
    always_comb begin
        w_state_next = ST_RUN;
        pc_sel       = 2'b00;
        fetch_le     = 1'b1;
        ifid_le      = 1'b1;
        ifid_clear   = 1'b0;
        idex_bubble  = 1'b0;
        taken        = 1'b0;
        annul        = 1'b0;
        w_stall_inc  = 1'b0;
        w_annul_inc  = 1'b0;
        w_ds_next    = 1'b0;
        w_dcti_set   = 1'b0;
        if (R) begin
            if (ex_jmpl) begin
                pc_sel     = 2'b10;
                taken      = 1'b1;
                ifid_clear = 1'b1;
                w_ds_next  = w_is_cti;
                w_dcti_set = w_is_cti;
            end else if ((r_state == ST_RUN) && w_hazard) begin
                // The stalled instruction stays in ID, so its delay-slot status is kept
                fetch_le     = 1'b0;
                ifid_le      = 1'b0;
                idex_bubble  = 1'b1;
                w_stall_inc  = 1'b1;
                w_state_next = ST_HOLD;
                w_ds_next    = r_ds_flag;
                w_dcti_set   = w_is_cti & r_ds_flag;
            end else begin
                w_ds_next = w_is_cti;
                if (w_is_cti && r_ds_flag) begin
                    w_dcti_set = 1'b1;
                end else begin
                    if (w_is_call || (w_is_bicc && w_cond_true)) begin
                        pc_sel = 2'b01;
                        taken  = 1'b1;
                    end
                    if (w_is_bicc && w_annul_bit &&
                        (!w_cond_true || (w_cond == 4'b1000))) begin
                        ifid_clear  = 1'b1;
                        annul       = 1'b1;
                        w_annul_inc = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_ds_flag   <= 1'b0;
            r_dcti_err  <= 1'b0;
            r_stall_cnt <= '0;
            r_annul_cnt <= '0;
        end else begin
            r_ds_flag  <= w_ds_next;
            r_dcti_err <= r_dcti_err | w_dcti_set;
            if (w_stall_inc && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
            if (w_annul_inc && (r_annul_cnt != C_CNT_MAX)) begin
                r_annul_cnt <= r_annul_cnt + C_CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign annul_cnt = r_annul_cnt;
    assign dcti_err  = r_dcti_err;

endmodule
`default_nettype wire
